spi_host_seq: RTL

- SPI host-side transaction sequencer for the BDC motor controller's SPI register interface.
- Accepts one command at a time: read/write flag, 7-bit address and 8-bit write data.
- Generates ss/sclk/mosi framing for one 16-bit transaction and captures miso read data.
- Sits between an on-chip command source (supervisor or test logic) and the motor controller `system` SPI slave; replaces hand-sequenced SPI bursts.

---
 rtl/spi_host_seq.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_host_seq.sv
// SPI host transaction sequencer: frames one 16-bit {rw, addr, wdata} command and captures read data.
// Optional 2-entry command FIFO in front of the FSM when SPI_HOST_SEQ_CMDBUF_EN is defined.
module spi_host_seq #(
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned SETUP       = 1,
  parameter int unsigned GAP         = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned MAX_HS  = (HALF_PERIOD > SETUP) ? HALF_PERIOD : SETUP;
  localparam int unsigned MAX_T   = (MAX_HS > GAP) ? MAX_HS : GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEAD, ST_LOW, ST_HIGH, ST_LAG, ST_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [7:0]           rx_q, rx_d;
  logic                 rw_q, rw_d;
  logic                 sclk_q, sclk_d;
  logic                 ss_q, ss_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 cmd_ready_q, cmd_ready_d;

  logic                 take;
  logic [FRAME_W-1:0]   take_frame;
  logic [FRAME_W-1:0]   cmd_frame;
  int unsigned          tmr_limit;
  logic                 tmr_end;

  assign cmd_frame = {cmd_rw, cmd_addr, cmd_wdata};

`ifdef SPI_HOST_SEQ_CMDBUF_EN
  logic [1:0][FRAME_W-1:0] fifo_q, fifo_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    push;

  assign push       = cmd_valid && cmd_ready_q;
  assign take       = (state_q == ST_IDLE) && (count_q != 2'd0);
  assign take_frame = fifo_q[rd_ptr_q];

  // FIFO bookkeeping; simultaneous push and pop leave the count unchanged
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = cmd_frame;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (take) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, take})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  assign take        = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign take_frame  = cmd_frame;
  assign cmd_ready_d = (state_d == ST_IDLE);
`endif

  // Dwell length of the current state; GAP is unreachable when GAP == 0
  always_comb begin
    unique case (state_q)
      ST_LEAD, ST_LAG: tmr_limit = SETUP;
      ST_LOW, ST_HIGH: tmr_limit = HALF_PERIOD;
      ST_GAP:          tmr_limit = GAP;
      default:         tmr_limit = 1;
    endcase
    tmr_end = (32'(cnt_q) + 32'd1 >= tmr_limit);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    if (state_q != ST_IDLE) begin
      cnt_d = tmr_end ? '0 : cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (take) begin
          tx_d    = take_frame;
          rw_d    = take_frame[FRAME_W-1];
          bit_d   = 4'd0;
          ss_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (tmr_end) begin
          state_d = ST_LOW;
          sclk_d  = 1'b0;
          mosi_d  = tx_q[FRAME_W-1];
        end
      end
      ST_LOW: begin
        // Rising sclk: capture miso and expose the next bit at tx MSB
        if (tmr_end) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], miso};
          tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
        end
      end
      ST_HIGH: begin
        if (tmr_end) begin
          if (bit_q == 4'd15) begin
            state_d = ST_LAG;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = ST_LOW;
            sclk_d  = 1'b0;
            mosi_d  = tx_q[FRAME_W-1];
          end
        end
      end
      ST_LAG: begin
        if (tmr_end) begin
          ss_d   = 1'b0;
          done_d = 1'b1;
          mosi_d = 1'b0;
          if (rw_q) begin
            rdata_d = rx_q;
          end
          if (GAP == 0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tmr_end) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      tx_q        <= '0;
      rx_q        <= 8'h00;
      rw_q        <= 1'b0;
      sclk_q      <= 1'b1;
      ss_q        <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 8'h00;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign sclk      = sclk_q;
  assign ss        = ss_q;
  assign mosi      = mosi_q;

endmodule
